dac_sample_feeder: RTL and testbench

Upstream stage for the dual-channel AD56x3 DAC driver. Buffers channel A/B sample pairs from a valid/ready source in a small synchronous FIFO. Generates the periodic `ce` sample strobe from a programmable divider and presents the popped pair on `dataA`/`dataB` in the same cycle, so the pair can be wired straight into the driver. Handles underflow deterministically and exposes fill level and underflow statistics.

---
 rtl/dac_feeder_pkg.sv | 17 +
 rtl/sample_fifo.sv | 68 ++++++
 rtl/dac_sample_feeder.sv | 157 +++++++++++++++
 tb/tb_dac_sample_feeder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_feeder_pkg.sv
// Shared constants and helpers for the DAC sample feeder.
// The midscale helper is only used when DAC_FEEDER_MIDSCALE_EN is defined.
package dac_feeder_pkg;

  localparam int unsigned UNDERFLOW_CNT_W = 16;

  // Code that puts the DAC output at mid-range for the given width and number format.
  function automatic logic [31:0] midscale(input int unsigned width, input bit signedFmt);
    logic [31:0] code;
    code = '0;
    if (!signedFmt) begin
      code = 32'd1 << (width - 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO with combinational head read and wrap-bit pointers.
// Depth must be a power of two so the binary pointers wrap naturally.
module sample_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers A/B sample pairs and releases one per ce strobe for the AD56x3 driver.
// Define DAC_FEEDER_MIDSCALE_EN to output midscale on underflow and after reset.
module dac_sample_feeder
  import dac_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 14,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned RATE_DIVIDER = 400,
  parameter int unsigned SIGNED_FMT   = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            flush,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic [DATA_WIDTH-1:0]           inDataA,
  input  logic [DATA_WIDTH-1:0]           inDataB,
  output logic                            ce,
  output logic [DATA_WIDTH-1:0]           dataA,
  output logic [DATA_WIDTH-1:0]           dataB,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            underflow,
  input  logic                            underflowClr,
  output logic [UNDERFLOW_CNT_W-1:0]      underflowCnt
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RC_W  = $clog2(RATE_DIVIDER);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RATE_DIVIDER - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } sample_pair_t;

`ifdef DAC_FEEDER_MIDSCALE_EN
  localparam logic [DATA_WIDTH-1:0] MID_CODE =
      DATA_WIDTH'(midscale(DATA_WIDTH, SIGNED_FMT != 0));
  localparam sample_pair_t RESET_PAIR = '{a: MID_CODE, b: MID_CODE};
`else
  localparam sample_pair_t RESET_PAIR = '0;
`endif

  if (SIGNED_FMT > 1) begin : g_bad_fmt
    $error("SIGNED_FMT must be 0 or 1");
  end
  if (RATE_DIVIDER < 2) begin : g_bad_rate
    $error("RATE_DIVIDER must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [RC_W-1:0]            rc_q, rc_d;
  logic                       ce_q, ce_d;
  sample_pair_t               out_q, out_d;
  logic                       uf_q, uf_d;
  logic [UNDERFLOW_CNT_W-1:0] cnt_q, cnt_d;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [LVL_W-1:0]           fifo_level;
  logic [2*DATA_WIDTH-1:0]    head_raw;
  sample_pair_t               head;
  sample_pair_t               in_pair;
  logic                       push;
  logic                       pop;
  logic                       tick;

  assign in_pair = '{a: inDataA, b: inDataB};
  assign head    = head_raw;
  assign inReady = ~fifo_full & ~flush;
  assign push    = inValid & inReady;
  // Flush restarts the period, so it also suppresses a tick landing in the same cycle.
  assign tick    = enable & ~flush & (rc_q == RC_LAST);
  assign pop     = tick & ~fifo_empty;

  sample_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (in_pair),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    rc_d = rc_q;
    if (flush || !enable) begin
      rc_d = '0;
    end else if (rc_q == RC_LAST) begin
      rc_d = '0;
    end else begin
      rc_d = rc_q + RC_W'(1);
    end
  end

  always_comb begin
    ce_d  = tick;
    out_d = out_q;
    if (pop) begin
      out_d = head;
    end else if (tick) begin
`ifdef DAC_FEEDER_MIDSCALE_EN
      out_d = RESET_PAIR;
`else
      out_d = out_q;
`endif
    end
  end

  always_comb begin
    uf_d  = uf_q;
    cnt_d = cnt_q;
    if (underflowClr) begin
      uf_d  = 1'b0;
      cnt_d = '0;
    end else if (tick && fifo_empty) begin
      uf_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + UNDERFLOW_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc_q  <= '0;
      ce_q  <= 1'b0;
      out_q <= RESET_PAIR;
      uf_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      rc_q  <= rc_d;
      ce_q  <= ce_d;
      out_q <= out_d;
      uf_q  <= uf_d;
      cnt_q <= cnt_d;
    end
  end

  assign ce           = ce_q;
  assign dataA        = out_q.a;
  assign dataB        = out_q.b;
  assign level        = fifo_level;
  assign underflow    = uf_q;
  assign underflowCnt = cnt_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Self-checking bench for dac_sample_feeder: a cycle model with a pair scoreboard checked
// every cycle, plus directed timing/data checks from the feeder's test plan.
module tb_dac_sample_feeder;

  localparam int unsigned DW    = 14;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RD    = 8;

`ifdef DAC_FEEDER_MIDSCALE_EN
  localparam bit MID_EN = 1'b1;
  localparam logic [DW-1:0] RST_CODE = 14'd8192;
`else
  localparam bit MID_EN = 1'b0;
  localparam logic [DW-1:0] RST_CODE = 14'd0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic          underflowClr = 1'b0;
  logic [DW-1:0] inDataA = '0;
  logic [DW-1:0] inDataB = '0;
  logic          inReady;
  logic          ce;
  logic [DW-1:0] dataA;
  logic [DW-1:0] dataB;
  logic [2:0]    level;
  logic          underflow;
  logic [15:0]   underflowCnt;

  int checks = 0;
  int errors = 0;

  dac_sample_feeder #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .RATE_DIVIDER (RD),
    .SIGNED_FMT   (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .flush        (flush),
    .inValid      (inValid),
    .inReady      (inReady),
    .inDataA      (inDataA),
    .inDataB      (inDataB),
    .ce           (ce),
    .dataA        (dataA),
    .dataB        (dataB),
    .level        (level),
    .underflow    (underflow),
    .underflowClr (underflowClr),
    .underflowCnt (underflowCnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle model: scoreboard of accepted pairs plus expected registered outputs.
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  pair_t         m_q[$];
  int            m_rc;
  logic          m_ce;
  logic [DW-1:0] m_a;
  logic [DW-1:0] m_b;
  logic          m_uf;
  int            m_cnt;

  task automatic model_reset();
    m_q.delete();
    m_rc  = 0;
    m_ce  = 1'b0;
    m_a   = RST_CODE;
    m_b   = RST_CODE;
    m_uf  = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    bit    tick;
    bit    acc;
    pair_t p;
    tick = enable && (m_rc == RD - 1) && !flush;
    acc  = inValid && (m_q.size() < DEPTH) && !flush;
    m_ce = tick;
    if (tick) begin
      if (m_q.size() > 0) begin
        p   = m_q.pop_front();
        m_a = p.a;
        m_b = p.b;
      end else begin
        if (MID_EN) begin
          m_a = 14'd8192;
          m_b = 14'd8192;
        end
        m_uf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    if (underflowClr) begin
      m_uf  = 1'b0;
      m_cnt = 0;
    end
    if (flush) m_q.delete();
    else if (acc) m_q.push_back({inDataA, inDataB});
    if (flush || !enable || m_rc == RD - 1) m_rc = 0;
    else m_rc++;
  endtask

  initial model_reset();

  // Inputs change 2 time units after posedge, so the negedge sees settled inputs and outputs.
  always @(negedge clk) begin
    if (reset) model_reset();
    check_eq("ce", 32'(ce), 32'(m_ce));
    check_eq("dataA", 32'(dataA), 32'(m_a));
    check_eq("dataB", 32'(dataB), 32'(m_b));
    check_eq("level", 32'(level), 32'(m_q.size()));
    check_eq("inReady", 32'(inReady), 32'((m_q.size() < DEPTH) && !flush));
    check_eq("underflow", 32'(underflow), 32'(m_uf));
    check_eq("underflowCnt", 32'(underflowCnt), 32'(m_cnt));
    if (!reset) model_step();
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_ce(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (!ce && k < 64);
    check_eq("ce_seen", 32'(ce), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [DW-1:0] hold_a;
    logic [DW-1:0] hold_b;

    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_inReady", 32'(inReady), 32'd1);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_dataA", 32'(dataA), 32'(RST_CODE));

    // Fill with enable low: four accepted, fifth refused.
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1;
      inDataA = DW'(2 * i + 1);
      inDataB = DW'(2 * i + 2);
      step(1);
    end
    inDataA = 14'd9;
    inDataB = 14'd10;
    #1;
    check_eq("full_inReady", 32'(inReady), 32'd0);
    check_eq("full_level", 32'(level), 32'd4);
    step(1);
    inValid = 1'b0;
    check_eq("full_level_hold", 32'(level), 32'd4);

    // Drain: ticks every RD cycles, oldest pair first.
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ce(k);
      check_eq("drain_gap", 32'(k), 32'(RD));
      check_eq("drain_a", 32'(dataA), 32'(2 * i + 1));
      check_eq("drain_b", 32'(dataB), 32'(2 * i + 2));
      check_eq("drain_level", 32'(level), 32'(3 - i));
    end

    // Underflow: hold (7,8) or midscale.
    hold_a = MID_EN ? 14'd8192 : 14'd7;
    hold_b = MID_EN ? 14'd8192 : 14'd8;
    wait_ce(k);
    check_eq("uf_gap", 32'(k), 32'(RD));
    check_eq("uf_a", 32'(dataA), 32'(hold_a));
    check_eq("uf_b", 32'(dataB), 32'(hold_b));
    check_eq("uf_flag", 32'(underflow), 32'd1);
    check_eq("uf_cnt", 32'(underflowCnt), 32'd1);
    step(7);
    underflowClr = 1'b1;
    step(1);
    underflowClr = 1'b0;
    check_eq("clr_ce", 32'(ce), 32'd1);
    check_eq("clr_flag", 32'(underflow), 32'd0);
    check_eq("clr_cnt", 32'(underflowCnt), 32'd0);

    // Push and pop in the same cycle at level 2.
    inValid = 1'b1; inDataA = 14'd11; inDataB = 14'd12;
    step(1);
    inDataA = 14'd13; inDataB = 14'd14;
    step(1);
    inValid = 1'b0;
    step(5);
    inValid = 1'b1; inDataA = 14'd15; inDataB = 14'd16;
    step(1);
    inValid = 1'b0;
    check_eq("sim_ce", 32'(ce), 32'd1);
    check_eq("sim_a", 32'(dataA), 32'd11);
    check_eq("sim_b", 32'(dataB), 32'd12);
    check_eq("sim_level", 32'(level), 32'd2);
    wait_ce(k);
    check_eq("sim2_a", 32'(dataA), 32'd13);
    wait_ce(k);
    check_eq("sim3_a", 32'(dataA), 32'd15);
    check_eq("sim3_level", 32'(level), 32'd0);

    // Push into an empty FIFO on a tick: no bypass.
    step(7);
    inValid = 1'b1; inDataA = 14'd17; inDataB = 14'd18;
    step(1);
    inValid = 1'b0;
    check_eq("nobyp_ce", 32'(ce), 32'd1);
    check_eq("nobyp_cnt", 32'(underflowCnt), 32'd1);
    check_eq("nobyp_level", 32'(level), 32'd1);
    check_eq("nobyp_a", 32'(dataA), 32'(MID_EN ? 14'd8192 : 14'd15));
    wait_ce(k);
    check_eq("nobyp_gap", 32'(k), 32'(RD));
    check_eq("nobyp2_a", 32'(dataA), 32'd17);
    check_eq("nobyp2_b", 32'(dataB), 32'd18);

    // Flush at level 3 mid-period; concurrent push is discarded.
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1;
      inDataA = DW'(21 + 2 * i);
      inDataB = DW'(22 + 2 * i);
      step(1);
    end
    inValid = 1'b0;
    check_eq("pre_flush_level", 32'(level), 32'd3);
    step(1);
    flush = 1'b1; inValid = 1'b1; inDataA = 14'd31; inDataB = 14'd32;
    #1;
    check_eq("flush_inReady", 32'(inReady), 32'd0);
    step(1);
    flush = 1'b0; inValid = 1'b0;
    check_eq("flush_level", 32'(level), 32'd0);
    wait_ce(k);
    check_eq("flush_gap", 32'(k), 32'(RD));
    check_eq("flush_cnt", 32'(underflowCnt), 32'd2);

    // Enable low for one cycle restarts the period.
    step(3);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    wait_ce(k);
    check_eq("en_gap", 32'(k), 32'(RD));

    // Asynchronous reset mid-period with level 2.
    inValid = 1'b1; inDataA = 14'd41; inDataB = 14'd42;
    step(1);
    inDataA = 14'd43; inDataB = 14'd44;
    step(1);
    inValid = 1'b0;
    step(1);
    check_eq("prerst_level", 32'(level), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    check_eq("arst_ce", 32'(ce), 32'd0);
    check_eq("arst_level", 32'(level), 32'd0);
    check_eq("arst_inReady", 32'(inReady), 32'd1);
    check_eq("arst_uf", 32'(underflow), 32'd0);
    check_eq("arst_cnt", 32'(underflowCnt), 32'd0);
    check_eq("arst_a", 32'(dataA), 32'(RST_CODE));
    check_eq("arst_b", 32'(dataB), 32'(RST_CODE));
    step(1);
    reset = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
